// File: rtl/camera_pkg.sv
// Shared types and constants for the camera AXI-Stream packer.
// Used by the top, the beat FIFO and the stream interface.
package camera_pkg;

   localparam int PIX_W      = 16;
   localparam int DATA_W     = 64;
   localparam int KEEP_W     = DATA_W / 8;
   localparam int LANES      = DATA_W / PIX_W;
   localparam int LANE_W     = $clog2(LANES);
   localparam int LANE_BYTES = PIX_W / 8;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_SOF = 2'd1,
      ACTIVE   = 2'd2
   } packer_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] tdata;
      logic [KEEP_W-1:0] tkeep;
      logic              tlast;
   } axis_beat_t;

   // Byte enables covering the lowest 'filled' pixel lanes.
   function automatic logic [KEEP_W-1:0] lane_keep(input int filled);
      logic [KEEP_W-1:0] keep;
      keep = '0;
      for (int b = 0; b < KEEP_W; b++) begin
         if ((b / LANE_BYTES) < filled) keep[b] = 1'b1;
      end
      return keep;
   endfunction

endpackage

// File: rtl/camera_axis_packer_if.sv
// AXI-Stream beat bus between the packer (master) and the DMA S2MM input (slave).
interface camera_axis_packer_if;
   import camera_pkg::*;

   logic [DATA_W-1:0] tdata;
   logic [KEEP_W-1:0] tkeep;
   logic              tlast;
   logic              tvalid;
   logic              tready;

   modport master (output tdata, tkeep, tlast, tvalid, input tready);
   modport slave  (input tdata, tkeep, tlast, tvalid, output tready);

endinterface

// File: rtl/packer_fifo.sv
// First-word-fall-through FIFO of packed beats with registered head outputs
// and an occupancy count for the writer's drop policy.
module packer_fifo
   import camera_pkg::*;
#(
   parameter int DEPTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  axis_beat_t             wr_beat,
   input  logic                   rd_en,
   output logic                   rd_valid,
   output axis_beat_t             rd_beat,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int AW    = $clog2(DEPTH);
   localparam int OCC_W = AW + 1;

   axis_beat_t mem [DEPTH];

   logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
   logic [OCC_W-1:0] occ_reg, occ_next, occ_after_rd;
   axis_beat_t       head_reg, head_next;
   logic             valid_reg, valid_next;
   logic             rd_fire, wr_fire;

   always_comb begin
      rd_fire      = rd_en && valid_reg;
      wr_fire      = wr_en && ((occ_reg < OCC_W'(DEPTH)) || rd_fire);
      occ_after_rd = occ_reg - OCC_W'(rd_fire);
      occ_next     = occ_after_rd + OCC_W'(wr_fire);
      rd_ptr_next  = rd_ptr_reg + AW'(rd_fire);
      wr_ptr_next  = wr_ptr_reg + AW'(wr_fire);
      valid_next   = (occ_next != '0);
      // Head comes from storage when older beats remain, else straight from the writer.
      head_next    = head_reg;
      if (occ_after_rd != '0) begin
         head_next = mem[rd_ptr_next];
      end else if (wr_fire) begin
         head_next = wr_beat;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         occ_reg    <= '0;
         head_reg   <= '0;
         valid_reg  <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         occ_reg    <= occ_next;
         head_reg   <= head_next;
         valid_reg  <= valid_next;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr_reg] <= wr_beat;
   end

   assign rd_valid  = valid_reg;
   assign rd_beat   = head_reg;
   assign occupancy = occ_reg;

endmodule

// File: rtl/camera_axis_packer.sv
// Packs 16-bit camera pixels four per 64-bit AXI-Stream beat for one armed frame.
// Optional PACKER_TESTPAT_EN: test_mode substitutes a per-frame pixel counter.
module camera_axis_packer
   import camera_pkg::*;
#(
   parameter int FIFO_DEPTH = 32,
   parameter int CNT_W      = 32
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic              capture,
   input  logic [15:0]       image_width,
   input  logic [15:0]       image_height,
   input  logic              test_mode,
   input  logic              pix_valid,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_sof,
   camera_axis_packer_if.master m_axis,
   output logic              busy,
   output logic              frame_done,
   output logic              err_short,
   output logic              err_overflow
);

   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   packer_state_t     state_reg, state_next;
   logic [CNT_W-1:0]  count_reg, count_next;
   logic [CNT_W-1:0]  expected_reg, expected_next;
   logic [DATA_W-1:0] pack_reg, pack_next;
   axis_beat_t        beat_reg, beat_next;
   logic              beat_valid_reg, beat_valid_next;
   logic              frame_done_reg, frame_done_next;
   logic              err_short_reg, err_short_next;
   logic              err_overflow_reg, err_overflow_next;

   logic [PIX_W-1:0]  pix_eff;
   logic [LANE_W-1:0] lane_sel;
   logic [DATA_W-1:0] merged;
   logic              take_pixel;
   logic              pop, accept_beat, fifo_wr, fifo_valid;
   axis_beat_t        fifo_head;
   logic [OCC_W-1:0]  occ;

`ifdef PACKER_TESTPAT_EN
   logic [PIX_W-1:0] tp_reg, tp_next, tp_val;

   always_comb begin
      tp_val  = pix_sof ? '0 : tp_reg;
      tp_next = tp_reg;
      if (pix_valid) tp_next = tp_val + PIX_W'(1);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) tp_reg <= '0;
      else            tp_reg <= tp_next;
   end

   assign pix_eff = test_mode ? tp_val : pix_data;
`else
   logic unused_test_mode;
   assign unused_test_mode = test_mode;
   assign pix_eff          = pix_data;
`endif

   assign lane_sel = count_reg[LANE_W-1:0];

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         assign merged[gi*PIX_W +: PIX_W] = (lane_sel == LANE_W'(gi)) ? pix_eff
                                          : pack_reg[gi*PIX_W +: PIX_W];
      end
   endgenerate

   // The last slot is held back for the frame's tlast beat.
   assign pop         = m_axis.tvalid && m_axis.tready;
   assign accept_beat = beat_reg.tlast ? ((occ < OCC_W'(FIFO_DEPTH)) || pop)
                                       : (occ < OCC_W'(FIFO_DEPTH - 1));
   assign fifo_wr     = beat_valid_reg && accept_beat;

   always_comb begin
      state_next        = state_reg;
      count_next        = count_reg;
      expected_next     = expected_reg;
      pack_next         = pack_reg;
      beat_next         = beat_reg;
      beat_valid_next   = 1'b0;
      frame_done_next   = 1'b0;
      err_short_next    = err_short_reg;
      err_overflow_next = err_overflow_reg;
      take_pixel        = 1'b0;

      case (state_reg)
         IDLE: begin
            if (capture && (image_width != '0) && (image_height != '0)) begin
               expected_next     = CNT_W'(image_width) * CNT_W'(image_height);
               count_next        = '0;
               pack_next         = '0;
               err_short_next    = 1'b0;
               err_overflow_next = 1'b0;
               state_next        = WAIT_SOF;
            end
         end
         WAIT_SOF: take_pixel = pix_valid && pix_sof;
         ACTIVE: begin
            if (pix_valid) begin
               if (pix_sof) begin
                  // Early SOF closes the frame with whatever lanes are filled.
                  beat_next.tdata = pack_reg;
                  beat_next.tkeep = lane_keep(int'(lane_sel));
                  beat_next.tlast = 1'b1;
                  beat_valid_next = 1'b1;
                  frame_done_next = 1'b1;
                  err_short_next  = 1'b1;
                  count_next      = '0;
                  pack_next       = '0;
                  state_next      = IDLE;
               end else begin
                  take_pixel = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (take_pixel) begin
         count_next = count_reg + CNT_W'(1);
         if ((count_reg + CNT_W'(1)) == expected_reg) begin
            beat_next.tdata = merged;
            beat_next.tkeep = lane_keep(int'(lane_sel) + 1);
            beat_next.tlast = 1'b1;
            beat_valid_next = 1'b1;
            frame_done_next = 1'b1;
            count_next      = '0;
            pack_next       = '0;
            state_next      = IDLE;
         end else if (lane_sel == LANE_W'(LANES - 1)) begin
            beat_next.tdata = merged;
            beat_next.tkeep = '1;
            beat_next.tlast = 1'b0;
            beat_valid_next = 1'b1;
            pack_next       = '0;
            state_next      = ACTIVE;
         end else begin
            pack_next  = merged;
            state_next = ACTIVE;
         end
      end

      if (beat_valid_reg && !accept_beat) err_overflow_next = 1'b1;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_reg        <= IDLE;
         count_reg        <= '0;
         expected_reg     <= '0;
         pack_reg         <= '0;
         beat_reg         <= '0;
         beat_valid_reg   <= 1'b0;
         frame_done_reg   <= 1'b0;
         err_short_reg    <= 1'b0;
         err_overflow_reg <= 1'b0;
      end else begin
         state_reg        <= state_next;
         count_reg        <= count_next;
         expected_reg     <= expected_next;
         pack_reg         <= pack_next;
         beat_reg         <= beat_next;
         beat_valid_reg   <= beat_valid_next;
         frame_done_reg   <= frame_done_next;
         err_short_reg    <= err_short_next;
         err_overflow_reg <= err_overflow_next;
      end
   end

   packer_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .wr_en     (fifo_wr),
      .wr_beat   (beat_reg),
      .rd_en     (m_axis.tready),
      .rd_valid  (fifo_valid),
      .rd_beat   (fifo_head),
      .occupancy (occ)
   );

   assign m_axis.tvalid = fifo_valid;
   assign m_axis.tdata  = fifo_head.tdata;
   assign m_axis.tkeep  = fifo_head.tkeep;
   assign m_axis.tlast  = fifo_head.tlast;

   assign busy         = (state_reg != IDLE);
   assign frame_done   = frame_done_reg;
   assign err_short    = err_short_reg;
   assign err_overflow = err_overflow_reg;

endmodule

// File: tb/tb_camera_axis_packer.sv
// Directed bench for camera_axis_packer: framing, partial/short frames,
// backpressure with overflow, reset recovery and the optional test pattern.
module tb_camera_axis_packer;
   import camera_pkg::*;

   logic             sys_clk      = 1'b0;
   logic             sys_rst_n    = 1'b0;
   logic             capture      = 1'b0;
   logic [15:0]      image_width  = '0;
   logic [15:0]      image_height = '0;
   logic             test_mode    = 1'b0;
   logic             pix_valid    = 1'b0;
   logic [PIX_W-1:0] pix_data     = '0;
   logic             pix_sof      = 1'b0;
   logic             busy, frame_done, err_short, err_overflow;

   camera_axis_packer_if axis_if();

   int                checks   = 0;
   int                errors   = 0;
   int                fd_count = 0;
   axis_beat_t        beats[$];
   logic              prev_stall = 1'b0;
   logic [DATA_W-1:0] prev_data  = '0;

   always #5 sys_clk = ~sys_clk;

   camera_axis_packer #(
      .FIFO_DEPTH (4),
      .CNT_W      (32)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .capture      (capture),
      .image_width  (image_width),
      .image_height (image_height),
      .test_mode    (test_mode),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .pix_sof      (pix_sof),
      .m_axis       (axis_if),
      .busy         (busy),
      .frame_done   (frame_done),
      .err_short    (err_short),
      .err_overflow (err_overflow)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Transfers are judged at the falling edge; inputs only change just after rising edges.
   always @(negedge sys_clk) begin
      axis_beat_t b;
      if (prev_stall && axis_if.tvalid) check("stall_hold_tdata", axis_if.tdata, prev_data);
      prev_stall = axis_if.tvalid && !axis_if.tready;
      prev_data  = axis_if.tdata;
      if (axis_if.tvalid && axis_if.tready) begin
         b.tdata = axis_if.tdata;
         b.tkeep = axis_if.tkeep;
         b.tlast = axis_if.tlast;
         beats.push_back(b);
         $display("beat %0d: tdata=%h tkeep=%h tlast=%b", beats.size() - 1, b.tdata, b.tkeep, b.tlast);
      end
      if (frame_done) fd_count++;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic start_test();
      beats.delete();
      fd_count = 0;
   endtask

   task automatic do_capture(input logic [15:0] w, input logic [15:0] h);
      tick();
      image_width  = w;
      image_height = h;
      capture      = 1'b1;
      tick();
      capture      = 1'b0;
   endtask

   task automatic send_pixels(input int n, input logic [15:0] base, input bit sof_first);
      for (int i = 0; i < n; i++) begin
         pix_valid = 1'b1;
         pix_data  = base + 16'(i);
         pix_sof   = sof_first && (i == 0);
         tick();
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic wait_beats(input int n);
      int cyc;
      cyc = 0;
      while (beats.size() < n && cyc < 200) begin
         @(negedge sys_clk);
         cyc++;
      end
      repeat (6) @(negedge sys_clk);
      check("beat_count", 64'(beats.size()), 64'(n));
   endtask

   task automatic check_beat(input int idx, input logic [63:0] d, input logic [7:0] k, input logic l);
      if (idx < beats.size()) begin
         check($sformatf("beat%0d_tdata", idx), beats[idx].tdata, d);
         check($sformatf("beat%0d_tkeep", idx), 64'(beats[idx].tkeep), 64'(k));
         check($sformatf("beat%0d_tlast", idx), 64'(beats[idx].tlast), 64'(l));
      end else begin
         check($sformatf("beat%0d_present", idx), 64'(beats.size()), 64'(idx + 1));
      end
   endtask

   initial begin
      logic [63:0] tp_exp;
      axis_if.tready = 1'b1;

      // Reset state
      repeat (3) @(negedge sys_clk);
      check("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
      check("rst_tdata", axis_if.tdata, 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_err_short", 64'(err_short), 64'd0);
      check("rst_err_overflow", 64'(err_overflow), 64'd0);
      tick();
      sys_rst_n = 1'b1;

      // Zero-size requests are ignored
      do_capture(16'd8, 16'd0);
      @(negedge sys_clk);
      check("zero_height_busy", 64'(busy), 64'd0);
      do_capture(16'd0, 16'd4);
      @(negedge sys_clk);
      check("zero_width_busy", 64'(busy), 64'd0);

      // Nominal 8x2 frame; the second capture arrives while busy
      start_test();
      do_capture(16'd8, 16'd2);
      @(negedge sys_clk);
      check("nominal_busy", 64'(busy), 64'd1);
      do_capture(16'd3, 16'd3);
      send_pixels(16, 16'h0001, 1'b1);
      wait_beats(4);
      check_beat(0, 64'h0004_0003_0002_0001, 8'hFF, 1'b0);
      check_beat(1, 64'h0008_0007_0006_0005, 8'hFF, 1'b0);
      check_beat(2, 64'h000C_000B_000A_0009, 8'hFF, 1'b0);
      check_beat(3, 64'h0010_000F_000E_000D, 8'hFF, 1'b1);
      check("nominal_frame_done", 64'(fd_count), 64'd1);
      check("nominal_idle", 64'(busy), 64'd0);

      // Partial last beat, 5x1
      start_test();
      do_capture(16'd5, 16'd1);
      send_pixels(5, 16'h00A0, 1'b1);
      wait_beats(2);
      check_beat(0, 64'h00A3_00A2_00A1_00A0, 8'hFF, 1'b0);
      check_beat(1, 64'h0000_0000_0000_00A4, 8'h03, 1'b1);
      check("partial_frame_done", 64'(fd_count), 64'd1);

      // Short frame: new SOF after 6 of 8 pixels
      start_test();
      do_capture(16'd8, 16'd1);
      send_pixels(6, 16'h00B0, 1'b1);
      send_pixels(1, 16'h00FF, 1'b1);
      wait_beats(2);
      check_beat(0, 64'h00B3_00B2_00B1_00B0, 8'hFF, 1'b0);
      check_beat(1, 64'h0000_0000_00B5_00B4, 8'h0F, 1'b1);
      check("short_err_short", 64'(err_short), 64'd1);
      check("short_idle", 64'(busy), 64'd0);
      check("short_frame_done", 64'(fd_count), 64'd1);

      // Backpressure: 32 pixels into a 4-deep FIFO with tready low
      start_test();
      axis_if.tready = 1'b0;
      do_capture(16'd32, 16'd1);
      @(negedge sys_clk);
      check("capture_clears_err_short", 64'(err_short), 64'd0);
      send_pixels(32, 16'h0100, 1'b1);
      repeat (4) @(negedge sys_clk);
      check("ovf_err_overflow", 64'(err_overflow), 64'd1);
      check("ovf_tvalid_held", 64'(axis_if.tvalid), 64'd1);
      check("ovf_head_tdata", axis_if.tdata, 64'h0103_0102_0101_0100);
      check("ovf_frame_done", 64'(fd_count), 64'd1);
      tick();
      axis_if.tready = 1'b1;
      wait_beats(4);
      check_beat(0, 64'h0103_0102_0101_0100, 8'hFF, 1'b0);
      check_beat(1, 64'h0107_0106_0105_0104, 8'hFF, 1'b0);
      check_beat(2, 64'h010B_010A_0109_0108, 8'hFF, 1'b0);
      check_beat(3, 64'h011F_011E_011D_011C, 8'hFF, 1'b1);
      check("ovf_drained_tvalid", 64'(axis_if.tvalid), 64'd0);

      // Reset mid-frame with a beat waiting in the FIFO
      start_test();
      axis_if.tready = 1'b0;
      do_capture(16'd8, 16'd1);
      send_pixels(5, 16'h0200, 1'b1);
      repeat (2) @(negedge sys_clk);
      check("pre_rst_tvalid", 64'(axis_if.tvalid), 64'd1);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_tvalid", 64'(axis_if.tvalid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_err_overflow", 64'(err_overflow), 64'd0);
      tick();
      tick();
      sys_rst_n      = 1'b1;
      axis_if.tready = 1'b1;
      start_test();
      do_capture(16'd4, 16'd1);
      send_pixels(4, 16'h00C0, 1'b1);
      wait_beats(1);
      check_beat(0, 64'h00C3_00C2_00C1_00C0, 8'hFF, 1'b1);

      // Test pattern request, 4x1
`ifdef PACKER_TESTPAT_EN
      tp_exp = 64'h0003_0002_0001_0000;
`else
      tp_exp = 64'h5A5D_5A5C_5A5B_5A5A;
`endif
      start_test();
      test_mode = 1'b1;
      do_capture(16'd4, 16'd1);
      send_pixels(4, 16'h5A5A, 1'b1);
      wait_beats(1);
      check_beat(0, tp_exp, 8'hFF, 1'b1);
      test_mode = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
